// File: rtl/sprite_collision_unit_pkg.sv
// Shared types and helpers for the sprite collision unit.
// Raster position width, frame-phase states, saturating increment.
package sprite_collision_unit_pkg;

    localparam int POS_W = 9;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        HOLD  = 2'd1,
        ACCUM = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] val,
        input logic [31:0] max_val
    );
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/sprite_collision_unit_sync_edge_detect.sv
// Registers a sync level and emits single-cycle rise/fall pulses.
// Shared by vsync- and hsync-driven blocks.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic level_q;

    // Previous-cycle copy of the level for edge comparison
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/sprite_collision_unit.sv
// Per-frame sprite collision detector with vsync-committed result record.
// Optional macro SPRITE_COLLISION_COUNT_EN exposes the pe pixel count.
module sprite_collision_unit
    import sprite_collision_unit_pkg::*;
#(
    parameter int CNT_W    = 10,
    parameter int MIN_HITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] vpos,
    input  logic             display_on,
    input  logic             vsync,
    input  logic             player_gfx,
    input  logic             enemy_gfx,
    input  logic             track_gfx,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             pe_flag,
    output logic             pt_flag,
    output logic [POS_W-1:0] first_x,
    output logic [POS_W-1:0] first_y,
    output logic             first_valid,
    output logic             overrun,
    output logic [CNT_W-1:0] pe_count
);

    localparam logic [31:0] CNT_MAX =
        32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [CNT_W-1:0] MIN_THR =
        CNT_W'(MIN_HITS);

    state_t           state;
    logic             vs_rise;
    logic             vs_fall;
    logic             commit;
    logic             pe_hit;
    logic             pt_hit;
    logic [CNT_W-1:0] pe_cnt;
    logic [CNT_W-1:0] pt_cnt;
    logic [CNT_W-1:0] pe_inc;
    logic [CNT_W-1:0] pt_inc;
    logic [POS_W-1:0] acc_x;
    logic [POS_W-1:0] acc_y;
    logic             acc_fv;

    sync_edge_detect u_vs_edge (
        .clk   (clk),
        .reset (reset),
        .level (vsync),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    assign pe_hit = display_on & player_gfx & enemy_gfx;
    assign pt_hit = display_on & player_gfx & track_gfx;
    assign commit = (state == ACCUM) & vs_rise;

    assign pe_inc = CNT_W'(sat_inc(32'(pe_cnt), CNT_MAX));
    assign pt_inc = CNT_W'(sat_inc(32'(pt_cnt), CNT_MAX));

    // Frame sequencer, pixel accumulation and committed record
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SYNC;
            pe_cnt       <= '0;
            pt_cnt       <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            acc_fv       <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            pe_flag      <= 1'b0;
            pt_flag      <= 1'b0;
            first_x      <= '0;
            first_y      <= '0;
            first_valid  <= 1'b0;
        end else begin
            if (result_valid && result_ack) begin
                result_valid <= 1'b0;
                overrun      <= 1'b0;
            end
            case (state)
                SYNC: begin
                    if (vs_rise) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (vs_fall) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (vs_rise) begin
                        state        <= HOLD;
                        pe_flag      <= (pe_cnt >= MIN_THR);
                        pt_flag      <= (pt_cnt >= MIN_THR);
                        first_x      <= acc_x;
                        first_y      <= acc_y;
                        first_valid  <= acc_fv;
                        result_valid <= 1'b1;
                        if (result_valid && !result_ack) begin
                            overrun <= 1'b1;
                        end
                        pe_cnt <= '0;
                        pt_cnt <= '0;
                        acc_x  <= '0;
                        acc_y  <= '0;
                        acc_fv <= 1'b0;
                    end else begin
                        if (pe_hit) begin
                            pe_cnt <= pe_inc;
                        end
                        if (pt_hit) begin
                            pt_cnt <= pt_inc;
                        end
                        if ((pe_hit || pt_hit) && !acc_fv) begin
                            acc_x  <= hpos;
                            acc_y  <= vpos;
                            acc_fv <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

`ifdef SPRITE_COLLISION_COUNT_EN
    // Publish the saturated pe count together with the flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe_count <= '0;
        end else if (commit) begin
            pe_count <= pe_cnt;
        end
    end
`else
    assign pe_count = '0;
    logic unused_commit;
    assign unused_commit = commit;
`endif

endmodule

// File: tb/tb_sprite_collision_unit.sv
// Scoreboard bench for sprite_collision_unit: two instances
// (CNT_W=10/MIN_HITS=1 and CNT_W=4/MIN_HITS=4) share one stimulus.
module tb_sprite_collision_unit;

    typedef struct packed {
        logic       rv;
        logic       pe;
        logic       pt;
        logic [8:0] fx;
        logic [8:0] fy;
        logic       fv;
        logic [9:0] cnt;
    } rec_t;

    typedef struct packed {
        rec_t a;
        rec_t b;
    } exp_t;

`ifdef SPRITE_COLLISION_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       display_on;
    logic       vsync;
    logic       player_gfx;
    logic       enemy_gfx;
    logic       track_gfx;
    logic       result_ack;

    logic       a_rv, a_pe, a_pt, a_fv, a_ov;
    logic [8:0] a_fx, a_fy;
    logic [9:0] a_cnt;
    logic       b_rv, b_pe, b_pt, b_fv, b_ov;
    logic [8:0] b_fx, b_fy;
    logic [3:0] b_cnt;

    rec_t obs_a;
    rec_t obs_b;
    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_req = 1'b0;

    always #5 clk = ~clk;

    sprite_collision_unit #(.CNT_W(10), .MIN_HITS(1)) dut_a (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .vsync(vsync),
        .player_gfx(player_gfx), .enemy_gfx(enemy_gfx),
        .track_gfx(track_gfx), .result_valid(a_rv),
        .result_ack(result_ack), .pe_flag(a_pe), .pt_flag(a_pt),
        .first_x(a_fx), .first_y(a_fy), .first_valid(a_fv),
        .overrun(a_ov), .pe_count(a_cnt)
    );

    sprite_collision_unit #(.CNT_W(4), .MIN_HITS(4)) dut_b (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .vsync(vsync),
        .player_gfx(player_gfx), .enemy_gfx(enemy_gfx),
        .track_gfx(track_gfx), .result_valid(b_rv),
        .result_ack(result_ack), .pe_flag(b_pe), .pt_flag(b_pt),
        .first_x(b_fx), .first_y(b_fy), .first_valid(b_fv),
        .overrun(b_ov), .pe_count(b_cnt)
    );

    assign obs_a = {a_rv, a_pe, a_pt, a_fx, a_fy, a_fv, a_cnt};
    assign obs_b = {b_rv, b_pe, b_pt, b_fx, b_fy, b_fv, 6'd0, b_cnt};

    function automatic exp_t expect_frame(
        input int n_pe, input int n_pt, input int x0, input int y0
    );
        exp_t r;
        bit   hit;
        int   sat;
        hit  = (n_pe + n_pt) > 0;
        sat  = (n_pe > 15) ? 15 : n_pe;
        r.a.rv  = 1'b1;
        r.a.pe  = (n_pe >= 1);
        r.a.pt  = (n_pt >= 1);
        r.a.fx  = hit ? 9'(x0) : 9'd0;
        r.a.fy  = hit ? 9'(y0) : 9'd0;
        r.a.fv  = hit;
        r.a.cnt = CNT_EN ? 10'(n_pe) : 10'd0;
        r.b     = r.a;
        r.b.pe  = (n_pe >= 4);
        r.b.pt  = (n_pt >= 4);
        r.b.cnt = CNT_EN ? 10'(sat) : 10'd0;
        return r;
    endfunction

    // Scoreboard: pop the expected record one cycle after each commit
    always @(negedge clk) begin
        if (chk_req) begin
            chk_req = 1'b0;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_underflow: no expected record queued");
            end else begin
                e = sb.pop_front();
                vectors++;
                if (obs_a !== e.a) begin
                    miscompares++;
                    $display("FAIL rec_a: got %h want %h", obs_a, e.a);
                end
                vectors++;
                if (obs_b !== e.b) begin
                    miscompares++;
                    $display("FAIL rec_b: got %h want %h", obs_b, e.b);
                end
            end
        end
    end

    task automatic set_pix(input logic d, input logic p,
                           input logic en, input logic t);
        display_on = d;
        player_gfx = p;
        enemy_gfx  = en;
        track_gfx  = t;
    endtask

    // One ACCUM frame: pe overlaps, then pt overlaps, then commit
    task automatic frame(input int n_pe, input int n_pt,
                         input int x0, input int y0,
                         input bit ack_c);
        for (int i = 0; i < n_pe; i++) begin
            @(negedge clk);
            set_pix(1, 1, 1, 0);
            hpos = 9'(x0 + i);
            vpos = 9'(y0);
        end
        for (int i = 0; i < n_pt; i++) begin
            @(negedge clk);
            set_pix(1, 1, 0, 1);
            hpos = 9'(x0 + n_pe + i);
            vpos = 9'(y0);
        end
        @(negedge clk);
        set_pix(0, 1, 1, 1);
        @(negedge clk);
        set_pix(1, 0, 1, 1);
        @(negedge clk);
        sb.push_back(expect_frame(n_pe, n_pt, x0, y0));
        vsync = 1'b1;
        set_pix(1, 1, 1, 1);
        hpos = 9'd1;
        vpos = 9'd1;
        result_ack = ack_c;
        @(posedge clk);
        chk_req = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vsync = 1'b0;
        set_pix(0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({obs_a, a_ov} !== '0) begin
            miscompares++;
            $display("FAIL reset_a: got %h want 0", {obs_a, a_ov});
        end
        vectors++;
        if ({obs_b, b_ov} !== '0) begin
            miscompares++;
            $display("FAIL reset_b: got %h want 0", {obs_b, b_ov});
        end
        reset = 1'b0;
    endtask

    task automatic test_sync_hold_ignore();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_pix(1, 1, 1, 1);
            hpos = 9'(10 + i);
            vpos = 9'd3;
        end
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vectors++;
        if ({a_rv, b_rv} !== 2'b00) begin
            miscompares++;
            $display("FAIL first_rise_commit: got %b want 00",
                     {a_rv, b_rv});
        end
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        set_pix(0, 0, 0, 0);
        @(negedge clk);
        frame(0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_ack(input logic pe_a_exp);
        @(negedge clk);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        vectors++;
        if ({a_rv, a_ov, b_rv, b_ov, a_pe} !== {4'b0000, pe_a_exp}) begin
            miscompares++;
            $display("FAIL ack: got %b want %b",
                     {a_rv, a_ov, b_rv, b_ov, a_pe}, {4'b0000, pe_a_exp});
        end
    endtask

    task automatic test_overrun();
        frame(4, 2, 20, 30, 1'b0);
        vectors++;
        if ({a_ov, b_ov} !== 2'b11) begin
            miscompares++;
            $display("FAIL overrun_set: got %b want 11", {a_ov, b_ov});
        end
    endtask

    task automatic test_back_to_back();
        frame(0, 5, 7, 9, 1'b0);
        frame(1, 1, 11, 12, 1'b0);
        vectors++;
        if ({a_ov, b_ov} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_overrun: got %b want 11", {a_ov, b_ov});
        end
        frame(2, 0, 13, 14, 1'b1);
        vectors++;
        if ({a_rv, a_ov, b_rv, b_ov} !== 4'b1010) begin
            miscompares++;
            $display("FAIL ack_with_commit: got %b want 1010",
                     {a_rv, a_ov, b_rv, b_ov});
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_pix(1, 1, 1, 1);
            hpos = 9'(40 + i);
            vpos = 9'd41;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({obs_a, a_ov, obs_b, b_ov} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got %h want 0",
                     {obs_a, a_ov, obs_b, b_ov});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vectors++;
        if ({a_rv, b_rv} !== 2'b00) begin
            miscompares++;
            $display("FAIL post_reset_rise: got %b want 00",
                     {a_rv, b_rv});
        end
        @(negedge clk);
        vsync = 1'b0;
        set_pix(0, 0, 0, 0);
        @(negedge clk);
        frame(1, 0, 5, 6, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        hpos = '0;
        vpos = '0;
        vsync = 1'b0;
        result_ack = 1'b0;
        set_pix(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        test_reset();
        test_sync_hold_ignore();
        test_ack(1'b0);
        frame(3, 0, 100, 50, 1'b0);
        test_overrun();
        test_ack(1'b1);
        test_back_to_back();
        frame(20, 0, 200, 100, 1'b0);
        test_reset_mid();
        repeat (2) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
